// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the ID-stage hazard/stall controller.
// Used by hazard_match and hazard_stall_controller.
package hazard_stall_controller_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic [4:0] XZR       = 5'd31;
    localparam logic [1:0] N_BR_EX   = 2'd2;
    localparam logic [1:0] N_BR_MEM  = 2'd1;
    localparam logic [1:0] N_LOADUSE = 2'd1;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/hazard_stall_controller_hazard_match.sv
// Combinational hazard comparator: returns the stall length N (0..2)
// required by the instruction in ID against the EX and MEM producers.
module hazard_match
    import hazard_stall_controller_pkg::*;
#(
    parameter logic [4:0] XZR = hazard_stall_controller_pkg::XZR
) (
    input  logic [4:0] id_rn,
    input  logic [4:0] id_rm2,
    input  logic       id_uses_rn,
    input  logic       id_uses_rm2,
    input  logic       id_branch_rn,
    input  logic [4:0] id_ex_rd,
    input  logic       id_ex_regwrite,
    input  logic       id_ex_memread,
    input  logic [4:0] ex_mem_rd,
    input  logic       ex_mem_regwrite,
    output logic [1:0] n_req
);

    // The zero register is a constant source, never a real dependency.
    function automatic logic reg_match(input logic       wen,
                                       input logic [4:0] rd,
                                       input logic [4:0] rs);
        return wen && (rd == rs) && (rs != XZR);
    endfunction

    logic ex_rn;
    logic ex_rm2;
    logic mem_rn;
    logic load_use;

    assign ex_rn    = reg_match(id_ex_regwrite, id_ex_rd, id_rn);
    assign ex_rm2   = reg_match(id_ex_regwrite, id_ex_rd, id_rm2);
    assign mem_rn   = reg_match(ex_mem_regwrite, ex_mem_rd, id_rn);
    assign load_use = id_ex_memread && ((id_uses_rn && ex_rn) || (id_uses_rm2 && ex_rm2));

    // NOTE: n_req gets a default before any conditional write so no latch is inferred.
    always_comb begin
        n_req = 2'd0;
        if (load_use && (N_LOADUSE > n_req)) n_req = N_LOADUSE;
        if (id_branch_rn && mem_rn && (N_BR_MEM > n_req)) n_req = N_BR_MEM;
        if (id_branch_rn && ex_rn && (N_BR_EX > n_req)) n_req = N_BR_EX;
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the ID stage: combinational stall in IDLE, a
// HOLD state with down-counter for multi-cycle branch-operand stalls.
// Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter logic [4:0] XZR = hazard_stall_controller_pkg::XZR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rn,
    input  logic [4:0]  id_rm2,
    input  logic        id_uses_rn,
    input  logic        id_uses_rm2,
    input  logic        id_branch_rn,
    input  logic [4:0]  id_ex_rd,
    input  logic        id_ex_regwrite,
    input  logic        id_ex_memread,
    input  logic [4:0]  ex_mem_rd,
    input  logic        ex_mem_regwrite,
    input  logic        branch_taken,
    output logic        stall,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        busy,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    logic [1:0] n_req;
    state_e     state;
    logic [1:0] cnt;

    hazard_match #(.XZR(XZR)) u_match (
        .id_rn           (id_rn),
        .id_rm2          (id_rm2),
        .id_uses_rn      (id_uses_rn),
        .id_uses_rm2     (id_uses_rm2),
        .id_branch_rn    (id_branch_rn),
        .id_ex_rd        (id_ex_rd),
        .id_ex_regwrite  (id_ex_regwrite),
        .id_ex_memread   (id_ex_memread),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_regwrite (ex_mem_regwrite),
        .n_req           (n_req)
    );

    // The IDLE cycle supplies the first stall; HOLD covers the remaining N-1.
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (n_req > 2'd1) begin
                        cnt   <= n_req - 2'd1;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    cnt <= cnt - 2'd1;
                    if (cnt <= 2'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset forces the pipeline-enable view regardless of hazard inputs.
    always_comb begin
        stall       = 1'b0;
        busy        = 1'b0;
        if_id_flush = 1'b0;
        if (!reset) begin
            stall       = (state == HOLD) || (n_req != 2'd0);
            busy        = (state == HOLD);
            if_id_flush = branch_taken && !stall;
        end
        pc_write    = !stall;
        if_id_write = !stall;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall)       stall_cnt_q <= sat_inc(stall_cnt_q);
            if (if_id_flush) flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed self-checking bench for hazard_stall_controller.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_hazard_stall_controller;

    logic        clock;
    logic        reset;
    logic [4:0]  id_rn;
    logic [4:0]  id_rm2;
    logic        id_uses_rn;
    logic        id_uses_rm2;
    logic        id_branch_rn;
    logic [4:0]  id_ex_rd;
    logic        id_ex_regwrite;
    logic        id_ex_memread;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_regwrite;
    logic        branch_taken;
    logic        stall;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        busy;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    logic [4:0]  outs;
    int          checks;
    int          errors;

    // Packed view: {stall, pc_write, if_id_write, if_id_flush, busy}
    assign outs = {stall, pc_write, if_id_write, if_id_flush, busy};

    hazard_stall_controller dut (
        .clock           (clock),
        .reset           (reset),
        .id_rn           (id_rn),
        .id_rm2          (id_rm2),
        .id_uses_rn      (id_uses_rn),
        .id_uses_rm2     (id_uses_rm2),
        .id_branch_rn    (id_branch_rn),
        .id_ex_rd        (id_ex_rd),
        .id_ex_regwrite  (id_ex_regwrite),
        .id_ex_memread   (id_ex_memread),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_regwrite (ex_mem_regwrite),
        .branch_taken    (branch_taken),
        .stall           (stall),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .busy            (busy),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clear_inputs();
        id_rn           = 5'd0;
        id_rm2          = 5'd0;
        id_uses_rn      = 1'b0;
        id_uses_rm2     = 1'b0;
        id_branch_rn    = 1'b0;
        id_ex_rd        = 5'd0;
        id_ex_regwrite  = 1'b0;
        id_ex_memread   = 1'b0;
        ex_mem_rd       = 5'd0;
        ex_mem_regwrite = 1'b0;
        branch_taken    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        id_ex_memread  = 1'b1;
        id_ex_regwrite = 1'b1;
        id_ex_rd       = 5'd2;
        id_rn          = 5'd2;
        id_uses_rn     = 1'b1;
        branch_taken   = 1'b1;
        @(negedge clock); #1;
        checks++;
        if (outs !== 5'b01100) begin errors++; $display("FAIL reset_outputs: outs=%b expected 01100", outs); end
        checks++;
        if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall_cycles: got %0h expected 0", stall_cycles); end
        checks++;
        if (flush_count !== 32'd0) begin errors++; $display("FAIL reset_flush_count: got %0h expected 0", flush_count); end
        @(negedge clock);
        clear_inputs();
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== 5'b01100) begin errors++; $display("FAIL reset_release: outs=%b expected 01100", outs); end
    endtask

    task automatic test_load_use();
        @(negedge clock);
        id_ex_memread  = 1'b1;
        id_ex_regwrite = 1'b1;
        id_ex_rd       = 5'd2;
        id_rn          = 5'd2;
        id_uses_rn     = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b10000) begin errors++; $display("FAIL load_use_stall: outs=%b expected 10000", outs); end
        @(negedge clock);
        id_ex_memread   = 1'b0;
        id_ex_regwrite  = 1'b0;
        id_ex_rd        = 5'd0;
        ex_mem_regwrite = 1'b1;
        ex_mem_rd       = 5'd2;
        #1;
        checks++;
        if (outs !== 5'b01100) begin errors++; $display("FAIL load_use_release: outs=%b expected 01100", outs); end
        @(negedge clock);
        clear_inputs();
    endtask

    task automatic test_branch_alu();
        @(negedge clock);
        id_ex_regwrite = 1'b1;
        id_ex_rd       = 5'd5;
        id_branch_rn   = 1'b1;
        id_rn          = 5'd5;
        id_uses_rn     = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b10000) begin errors++; $display("FAIL br_alu_cycle1: outs=%b expected 10000", outs); end
        @(negedge clock);
        id_ex_regwrite  = 1'b0;
        id_ex_rd        = 5'd0;
        ex_mem_regwrite = 1'b1;
        ex_mem_rd       = 5'd5;
        #1;
        checks++;
        if (outs !== 5'b10001) begin errors++; $display("FAIL br_alu_cycle2_hold: outs=%b expected 10001", outs); end
        @(negedge clock);
        ex_mem_regwrite = 1'b0;
        ex_mem_rd       = 5'd0;
        branch_taken    = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b01110) begin errors++; $display("FAIL br_alu_flush: outs=%b expected 01110", outs); end
        @(negedge clock);
        clear_inputs();
        #1;
        checks++;
        if (outs !== 5'b01100) begin errors++; $display("FAIL br_alu_after: outs=%b expected 01100", outs); end
    endtask

    task automatic test_branch_mem();
        @(negedge clock);
        ex_mem_regwrite = 1'b1;
        ex_mem_rd       = 5'd7;
        id_branch_rn    = 1'b1;
        id_rn           = 5'd7;
        id_uses_rn      = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b10000) begin errors++; $display("FAIL br_mem_stall: outs=%b expected 10000", outs); end
        @(negedge clock);
        ex_mem_regwrite = 1'b0;
        #1;
        checks++;
        if (outs !== 5'b01100) begin errors++; $display("FAIL br_mem_release: outs=%b expected 01100", outs); end
        @(negedge clock);
        ex_mem_regwrite = 1'b1;
        ex_mem_rd       = 5'd31;
        id_rn           = 5'd31;
        #1;
        checks++;
        if (outs !== 5'b01100) begin errors++; $display("FAIL br_mem_xzr: outs=%b expected 01100", outs); end
        @(negedge clock);
        ex_mem_regwrite = 1'b0;
        id_ex_regwrite  = 1'b1;
        id_ex_rd        = 5'd31;
        #1;
        checks++;
        if (outs !== 5'b01100) begin errors++; $display("FAIL br_ex_xzr: outs=%b expected 01100", outs); end
        @(negedge clock);
        clear_inputs();
    endtask

    task automatic test_perf_counts(input logic [31:0] exp_stall, input logic [31:0] exp_flush, input string tag);
        @(negedge clock); #1;
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (stall_cycles !== exp_stall) begin errors++; $display("FAIL %s_stall_cycles: got %0d expected %0d", tag, stall_cycles, exp_stall); end
        checks++;
        if (flush_count !== exp_flush) begin errors++; $display("FAIL %s_flush_count: got %0d expected %0d", tag, flush_count, exp_flush); end
`else
        checks++;
        if (stall_cycles !== 32'd0) begin errors++; $display("FAIL %s_stall_cycles_off: got %0d expected 0 (want %0d when enabled)", tag, stall_cycles, exp_stall); end
        checks++;
        if (flush_count !== 32'd0) begin errors++; $display("FAIL %s_flush_count_off: got %0d expected 0 (want %0d when enabled)", tag, flush_count, exp_flush); end
`endif
    endtask

    task automatic test_load_use_variants();
        // Load-use via second read register only.
        @(negedge clock);
        clear_inputs();
        id_ex_memread = 1'b1; id_ex_regwrite = 1'b1; id_ex_rd = 5'd12;
        id_rm2 = 5'd12; id_uses_rm2 = 1'b1; id_rn = 5'd12;
        #1;
        checks++;
        if (outs !== 5'b10000) begin errors++; $display("FAIL lu_rm2: outs=%b expected 10000", outs); end
        // Register matches but is not read.
        @(negedge clock);
        clear_inputs();
        id_ex_memread = 1'b1; id_ex_regwrite = 1'b1; id_ex_rd = 5'd12; id_rn = 5'd12; id_rm2 = 5'd12;
        #1;
        checks++;
        if (outs !== 5'b01100) begin errors++; $display("FAIL lu_not_used: outs=%b expected 01100", outs); end
        // ALU producer in EX is forwarded, no stall.
        @(negedge clock);
        clear_inputs();
        id_ex_regwrite = 1'b1; id_ex_rd = 5'd12; id_rn = 5'd12; id_uses_rn = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b01100) begin errors++; $display("FAIL lu_alu_forward: outs=%b expected 01100", outs); end
        // Load into XZR.
        @(negedge clock);
        clear_inputs();
        id_ex_memread = 1'b1; id_ex_regwrite = 1'b1; id_ex_rd = 5'd31; id_rn = 5'd31; id_uses_rn = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b01100) begin errors++; $display("FAIL lu_xzr: outs=%b expected 01100", outs); end
        // Load without regwrite.
        @(negedge clock);
        clear_inputs();
        id_ex_memread = 1'b1; id_ex_rd = 5'd12; id_rn = 5'd12; id_uses_rn = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b01100) begin errors++; $display("FAIL lu_no_regwrite: outs=%b expected 01100", outs); end
        @(negedge clock);
        clear_inputs();
    endtask

    task automatic test_simultaneous();
        @(negedge clock);
        ex_mem_regwrite = 1'b1; ex_mem_rd = 5'd7;
        id_branch_rn = 1'b1; id_rn = 5'd7; id_uses_rn = 1'b1;
        branch_taken = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b10000) begin errors++; $display("FAIL simul_stall_wins: outs=%b expected 10000", outs); end
        @(negedge clock);
        ex_mem_regwrite = 1'b0;
        #1;
        checks++;
        if (outs !== 5'b01110) begin errors++; $display("FAIL simul_flush_next: outs=%b expected 01110", outs); end
        @(negedge clock);
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        id_ex_regwrite = 1'b1; id_ex_rd = 5'd3;
        id_branch_rn = 1'b1; id_rn = 5'd3; id_uses_rn = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b10000) begin errors++; $display("FAIL b2b_branch: outs=%b expected 10000", outs); end
        @(negedge clock);
        clear_inputs();
        #1;
        checks++;
        if (outs !== 5'b10001) begin errors++; $display("FAIL b2b_hold_ignores_inputs: outs=%b expected 10001", outs); end
        @(negedge clock);
        id_ex_memread = 1'b1; id_ex_regwrite = 1'b1; id_ex_rd = 5'd4;
        id_rm2 = 5'd4; id_uses_rm2 = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b10000) begin errors++; $display("FAIL b2b_chain_load_use: outs=%b expected 10000", outs); end
        @(negedge clock);
        clear_inputs();
        #1;
        checks++;
        if (outs !== 5'b01100) begin errors++; $display("FAIL b2b_done: outs=%b expected 01100", outs); end
    endtask

    task automatic test_reset_mid_hold();
        @(negedge clock);
        id_ex_regwrite = 1'b1; id_ex_rd = 5'd9;
        id_branch_rn = 1'b1; id_rn = 5'd9; id_uses_rn = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b10000) begin errors++; $display("FAIL rst_hold_entry: outs=%b expected 10000", outs); end
        @(negedge clock);
        clear_inputs();
        branch_taken = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b10001) begin errors++; $display("FAIL rst_hold_state: outs=%b expected 10001", outs); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b01100) begin errors++; $display("FAIL rst_hold_async: outs=%b expected 01100", outs); end
        branch_taken = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== 5'b01100) begin errors++; $display("FAIL rst_hold_release: outs=%b expected 01100", outs); end
        @(negedge clock); #1;
        checks++;
        if (outs !== 5'b01100) begin errors++; $display("FAIL rst_hold_stays_idle: outs=%b expected 01100", outs); end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_saturation();
        @(negedge clock);
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.stall_cnt_q;
        id_ex_memread = 1'b1; id_ex_regwrite = 1'b1; id_ex_rd = 5'd2;
        id_rn = 5'd2; id_uses_rn = 1'b1;
        @(negedge clock); #1;
        checks++;
        if (stall_cycles !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_reach_max: got %h expected ffffffff", stall_cycles); end
        @(negedge clock); #1;
        checks++;
        if (stall_cycles !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_no_wrap: got %h expected ffffffff", stall_cycles); end
        clear_inputs();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_use();
        test_branch_alu();
        test_branch_mem();
        test_perf_counts(32'd4, 32'd1, "perf_three_scenarios");
        test_load_use_variants();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_hold();
        test_perf_counts(32'd0, 32'd0, "perf_after_reset");
`ifdef HAZARD_PERF_CNT_EN
        test_perf_saturation();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
